// File: rtl/seg_data_src_pkg.sv
// Widths and defaults shared between the value source and the dynamic display stage.
package seg_data_src_pkg;

  localparam int DATA_W  = 20;
  localparam int POINT_W = 6;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [POINT_W-1:0] point_t;

  localparam data_t DATA_MAX_DEF = 20'd99_999;

endpackage

// File: rtl/seg_data_src_if.sv
// Display bus from the value source (master) to the dynamic display stage (slave).
interface seg_data_src_if;
  import seg_data_src_pkg::*;

  data_t  data;
  point_t point;
  logic   sign;
  logic   seg_en;

  modport master (output data, output point, output sign, output seg_en);
  modport slave  (input  data, input  point, input  sign, input  seg_en);

endinterface

// File: rtl/seg_data_src_key_filter.sv
// Push-button conditioning: 2-flop synchronizer, stable-low debounce and press pulse.
// Auto-repeat counters exist only when SEG_KEY_REPEAT_EN is defined.
module key_filter #(
  parameter logic [19:0] CNT_MAX = 20'd999_999,
  parameter logic [24:0] REP_DLY = 25'd24_999_999,
  parameter logic [22:0] REP_PER = 23'd4_999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);

  logic [1:0]  sync_q;
  logic        key_s;
  logic [19:0] cnt_q, cnt_d;
  logic        held_q, held_d;
  logic        first_pulse;

  assign key_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  // held_q marks a press already reported; only a high sample re-arms the filter.
  assign first_pulse = !key_s && !held_q && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d  = cnt_q;
    held_d = held_q;
    if (key_s) begin
      cnt_d  = '0;
      held_d = 1'b0;
    end else if (!held_q) begin
      if (cnt_q == CNT_MAX) begin
        held_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      held_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      held_q <= held_d;
    end
  end

`ifdef SEG_KEY_REPEAT_EN
  localparam logic [0:0] PH_DELAY  = 1'b0;
  localparam logic [0:0] PH_PERIOD = 1'b1;

  logic [24:0] rep_cnt_q, rep_cnt_d;
  logic [24:0] rep_lim;
  logic [0:0]  ph_q, ph_d;
  logic        rep_pulse;

  assign rep_lim   = (ph_q == PH_DELAY) ? REP_DLY : {2'b00, REP_PER};
  assign rep_pulse = !key_s && held_q && (rep_cnt_q == rep_lim);

  // The long initial delay applies once per hold, then the short period repeats.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    ph_d      = ph_q;
    if (key_s || !held_q) begin
      rep_cnt_d = '0;
      ph_d      = PH_DELAY;
    end else if (rep_pulse) begin
      rep_cnt_d = '0;
      ph_d      = PH_PERIOD;
    end else begin
      rep_cnt_d = rep_cnt_q + 25'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      ph_q      <= PH_DELAY;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      ph_q      <= ph_d;
    end
  end

  assign press_o = first_pulse | rep_pulse;
`else
  assign press_o = first_pulse;
`endif

endmodule

// File: rtl/seg_data_src.sv
// Up/down sign+magnitude value source for the 6-digit display, saturating at +/-DATA_MAX.
// Optional auto-repeat on held keys is enabled by defining SEG_KEY_REPEAT_EN.
module seg_data_src
  import seg_data_src_pkg::*;
#(
  parameter logic [19:0] CNT_20MS = 20'd999_999,
  parameter logic [24:0] REP_DLY  = 25'd24_999_999,
  parameter logic [22:0] REP_PER  = 23'd4_999_999,
  parameter data_t       DATA_MAX = DATA_MAX_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  key_up,
  input  logic                  key_down,
  seg_data_src_if.master        disp
);

  logic  up_p, dn_p;
  data_t mag_q, mag_d;
  logic  sign_q, sign_d;
  logic  seg_en_q;

  key_filter #(
    .CNT_MAX (CNT_20MS),
    .REP_DLY (REP_DLY),
    .REP_PER (REP_PER)
  ) u_key_up (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .key_i   (key_up),
    .press_o (up_p)
  );

  key_filter #(
    .CNT_MAX (CNT_20MS),
    .REP_DLY (REP_DLY),
    .REP_PER (REP_PER)
  ) u_key_down (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .key_i   (key_down),
    .press_o (dn_p)
  );

  // Stepping is done on the magnitude so zero never carries a negative sign.
  always_comb begin
    mag_d  = mag_q;
    sign_d = sign_q;
    if (up_p && !dn_p) begin
      if (!sign_q) begin
        if (mag_q < DATA_MAX) mag_d = mag_q + data_t'(1);
      end else begin
        mag_d = mag_q - data_t'(1);
        if (mag_q == data_t'(1)) sign_d = 1'b0;
      end
    end else if (dn_p && !up_p) begin
      if (sign_q) begin
        if (mag_q < DATA_MAX) mag_d = mag_q + data_t'(1);
      end else if (mag_q != '0) begin
        mag_d = mag_q - data_t'(1);
      end else if (DATA_MAX != '0) begin
        mag_d  = data_t'(1);
        sign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mag_q    <= '0;
      sign_q   <= 1'b0;
      seg_en_q <= 1'b0;
    end else begin
      mag_q    <= mag_d;
      sign_q   <= sign_d;
      seg_en_q <= 1'b1;
    end
  end

  assign disp.data   = mag_q;
  assign disp.point  = '0;
  assign disp.sign   = sign_q;
  assign disp.seg_en = seg_en_q;

endmodule

// File: tb/tb_seg_data_src.sv
// Self-checking bench for seg_data_src with short debounce/repeat intervals and DATA_MAX=12.
module tb_seg_data_src;

  localparam int CNT  = 19;
  localparam int RDLY = 49;
  localparam int RPER = 9;
  localparam int DMAX = 12;

  logic sys_clk;
  logic sys_rst_n;
  logic key_up;
  logic key_down;

  int testsRun;
  int testsFailed;
  int modelVal;

  seg_data_src_if disp ();

  seg_data_src #(
    .CNT_20MS (20'd19),
    .REP_DLY  (25'd49),
    .REP_PER  (23'd9),
    .DATA_MAX (20'd12)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_up    (key_up),
    .key_down  (key_down),
    .disp      (disp)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference behaviour: a signed integer stepped by one and clamped to +/-DMAX.
  function automatic int stepModel(int v, bit up, bit dn);
    if (up && !dn && v < DMAX) return v + 1;
    if (dn && !up && v > -DMAX) return v - 1;
    return v;
  endfunction

  function automatic logic [19:0] expMag(int v);
    return (v < 0) ? 20'(-v) : 20'(v);
  endfunction

  function automatic logic expSign(int v);
    return (v < 0);
  endfunction

  // Number of press pulses seen after s consecutive synchronized low samples.
  function automatic int pulsesAfter(int s);
    int p;
    p = 0;
    if (s >= CNT + 1) p = 1;
`ifdef SEG_KEY_REPEAT_EN
    if (s >= CNT + 1 + RDLY + 1) p = p + 1 + (s - (CNT + 1 + RDLY + 1)) / (RPER + 1);
`endif
    return p;
  endfunction

  // Optional bounce burst, a hold of 'hold' cycles, release, then 'gap' idle cycles.
  task automatic applyStimulus(input bit up, input bit dn, input int hold, input int gap,
                               input int bounces);
    for (int b = 0; b < bounces; b++) begin
      key_up = !up; key_down = !dn;
      repeat ($urandom_range(1, 3)) tick();
      key_up = 1'b1; key_down = 1'b1;
      repeat ($urandom_range(1, 2)) tick();
    end
    key_up = !up; key_down = !dn;
    repeat (hold) tick();
    key_up = 1'b1; key_down = 1'b1;
    repeat (gap) tick();
    if (hold >= CNT + 1) modelVal = stepModel(modelVal, up, dn);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1;
    key_up = 1'b1; key_down = 1'b1;
    #2 sys_rst_n = 1'b0;
    repeat (3) tick();
    testsRun++;
    if (disp.data !== 20'd0 || disp.sign !== 1'b0 || disp.point !== 6'd0 || disp.seg_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL in_reset: data=%0d sign=%0b point=%b seg_en=%0b expected 0/0/000000/0",
               disp.data, disp.sign, disp.point, disp.seg_en);
    end
    sys_rst_n = 1'b1;
    #1;
    testsRun++;
    if (disp.seg_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL seg_en_before_edge: seg_en=%0b expected 0", disp.seg_en);
    end
    tick();
    testsRun++;
    if (disp.data !== 20'd0 || disp.sign !== 1'b0 || disp.point !== 6'd0 || disp.seg_en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL after_release: data=%0d sign=%0b point=%b seg_en=%0b expected 0/0/000000/1",
               disp.data, disp.sign, disp.point, disp.seg_en);
    end
    modelVal = 0;
  endtask

  task automatic test_bounce();
    key_up = 1'b0; tick();
    key_up = 1'b1; tick();
    key_up = 1'b0; tick();
    key_up = 1'b1; tick();
    key_up = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 21) begin
        testsRun++;
        if (disp.data !== 20'd0) begin
          testsFailed++;
          $display("[TB] FAIL bounce_early: data=%0d expected 0 at cycle 21", disp.data);
        end
      end
      if (n == 22) begin
        testsRun++;
        if (disp.data !== 20'd1 || disp.sign !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL bounce_latency: data=%0d sign=%0b expected 1/0 at cycle 22",
                   disp.data, disp.sign);
        end
      end
    end
    key_up = 1'b1;
    repeat (5) tick();
    testsRun++;
    if (disp.data !== 20'd1) begin
      testsFailed++;
      $display("[TB] FAIL bounce_single: data=%0d expected 1", disp.data);
    end
    modelVal = 1;
  endtask

  task automatic test_debounce_boundary();
    applyStimulus(1'b0, 1'b1, CNT, 6, 0);
    testsRun++;
    if (disp.data !== 20'd1 || disp.sign !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL short_hold: data=%0d sign=%0b expected 1/0", disp.data, disp.sign);
    end
    applyStimulus(1'b0, 1'b1, CNT + 1, 6, 0);
    testsRun++;
    if (disp.data !== 20'd0 || disp.sign !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL exact_hold: data=%0d sign=%0b expected 0/0", disp.data, disp.sign);
    end
  endtask

  task automatic test_up_down();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 30, 6, 0);
    testsRun++;
    if (disp.data !== 20'd3 || disp.sign !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL three_down: data=%0d sign=%0b expected 3/1", disp.data, disp.sign);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 30, 6, 0);
      testsRun++;
      if (disp.data !== expMag(modelVal) || disp.sign !== expSign(modelVal)) begin
        testsFailed++;
        $display("[TB] FAIL up_step%0d: data=%0d sign=%0b expected %0d/%0b",
                 i, disp.data, disp.sign, expMag(modelVal), expSign(modelVal));
      end
    end
    testsRun++;
    if (disp.data !== 20'd0 || disp.sign !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL back_to_zero: data=%0d sign=%0b expected 0/0", disp.data, disp.sign);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < DMAX + 2; i++) applyStimulus(1'b1, 1'b0, 25, 5, 0);
    testsRun++;
    if (disp.data !== 20'd12 || disp.sign !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL sat_pos: data=%0d sign=%0b expected 12/0", disp.data, disp.sign);
    end
    for (int i = 0; i < 2 * DMAX + 2; i++) applyStimulus(1'b0, 1'b1, 25, 5, 0);
    testsRun++;
    if (disp.data !== 20'd12 || disp.sign !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL sat_neg: data=%0d sign=%0b expected 12/1", disp.data, disp.sign);
    end
  endtask

  task automatic test_both_keys();
    applyStimulus(1'b1, 1'b1, 30, 6, 0);
    testsRun++;
    if (disp.data !== 20'd12 || disp.sign !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL both_cancel: data=%0d sign=%0b expected 12/1", disp.data, disp.sign);
    end
  endtask

  task automatic test_reset_mid_press();
    key_up = 1'b0;
    repeat (10) tick();
    sys_rst_n = 1'b0;
    #1;
    testsRun++;
    if (disp.data !== 20'd0 || disp.sign !== 1'b0 || disp.seg_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_press_reset: data=%0d sign=%0b seg_en=%0b expected 0/0/0",
               disp.data, disp.sign, disp.seg_en);
    end
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (15) tick();
    key_up = 1'b1;
    repeat (6) tick();
    testsRun++;
    if (disp.data !== 20'd0 || disp.sign !== 1'b0 || disp.seg_en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL press_discarded: data=%0d sign=%0b seg_en=%0b expected 0/0/1",
               disp.data, disp.sign, disp.seg_en);
    end
    modelVal = 0;
  endtask

  task automatic test_repeat();
    int s, expVal, base;
    base = modelVal;
    key_up = 1'b0;
    for (int n = 1; n <= 106; n++) begin
      tick();
      if (n == 100) key_up = 1'b1;
      s = n - 2;
      if (s < 0) s = 0;
      if (s > 100) s = 100;
      expVal = base + pulsesAfter(s);
      if (expVal > DMAX) expVal = DMAX;
      testsRun++;
      if (disp.data !== expMag(expVal) || disp.sign !== expSign(expVal)) begin
        testsFailed++;
        $display("[TB] FAIL hold_cycle%0d: data=%0d sign=%0b expected %0d/%0b",
                 n, disp.data, disp.sign, expMag(expVal), expSign(expVal));
      end
    end
    modelVal = expVal;
  endtask

  task automatic test_random();
    bit up, dn;
    int kind;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 5);
      up = (kind <= 2) || (kind == 5);
      dn = (kind >= 3);
      applyStimulus(up, dn, $urandom_range(10, 60), $urandom_range(4, 10), $urandom_range(0, 3));
      testsRun++;
      if (disp.data !== expMag(modelVal) || disp.sign !== expSign(modelVal)) begin
        testsFailed++;
        $display("[TB] FAIL random%0d: data=%0d sign=%0b expected %0d/%0b",
                 i, disp.data, disp.sign, expMag(modelVal), expSign(modelVal));
      end
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    modelVal = 0;
    key_up = 1'b1;
    key_down = 1'b1;
    test_reset();
    test_bounce();
    test_debounce_boundary();
    test_up_down();
    test_saturation();
    test_both_keys();
    test_reset_mid_press();
    test_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
